// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the modular exponentiation engine and its reducer.
// The latency helpers are also used by verification to predict completion time.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE_BASE,
        MULTIPLY,
        SQUARE,
        DONE
    } state_t;

    // Cycles spent in each state that issues a reduction: 1 issue + 2*width+1 in the reducer.
    function automatic int red_cycles(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int msb_index(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // Accept edge to the sample point at which valid_out is seen high.
    function automatic int latency_cycles(input int width, input logic [63:0] exponent);
        return (1 + popcount(exponent) + msb_index(exponent)) * red_cycles(width) + 1;
    endfunction

endpackage

// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: remainder of a 2*WIDTH dividend by a WIDTH modulus.
// One dividend bit per cycle, so valid_out rises exactly 2*WIDTH cycles after accept.
module mod_reduce
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic [2*WIDTH-1:0]   dividend_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     remainder_out,
    output logic                 busy_out,
    output logic                 valid_out
);

    localparam int ITERS = red_cycles(WIDTH) - 2;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [2*WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0]   mod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   rem_next;

    // The partial remainder stays below the modulus, so after subtraction it fits WIDTH bits.
    always_comb begin
        shifted  = {rem_q, dvd_q[2*WIDTH-1]};
        rem_next = shifted[WIDTH-1:0];
        if (shifted >= {1'b0, mod_q}) rem_next = WIDTH'(shifted - {1'b0, mod_q});
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dvd_q     <= '0;
            mod_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_out  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (!busy_out && ready_in) begin
                dvd_q    <= dividend_in;
                mod_q    <= modulus_in;
                rem_q    <= '0;
                cnt_q    <= '0;
                busy_out <= 1'b1;
            end else if (busy_out) begin
                rem_q <= rem_next;
                dvd_q <= dvd_q << 1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    busy_out  <= 1'b0;
                    valid_out <= 1'b1;
                end
            end
        end
    end

    assign remainder_out = rem_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation; every product is reduced
// immediately by mod_reduce so operands never exceed 2*WIDTH bits.
module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out
);

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q, b_q, m_q;
    logic [EXP_WIDTH-1:0] e_q, e_shr;
    logic                 issued_q;

    logic                 accept;
    logic                 red_start, red_busy, red_valid;
    logic [2*WIDTH-1:0]   red_dividend;
    logic [WIDTH-1:0]     red_modulus, red_rem;

    assign accept = ready_in && !busy_out;
    assign e_shr  = e_q >> 1;

    // Base reduction is issued straight from the inputs in the accept cycle.
    always_comb begin
        red_start    = 1'b0;
        red_dividend = '0;
        red_modulus  = m_q;
        case (state_q)
            IDLE: begin
                red_start    = accept && (modulus_in != '0);
                red_dividend = {{WIDTH{1'b0}}, base_in};
                red_modulus  = modulus_in;
            end
            MULTIPLY: begin
                red_start    = !issued_q;
                red_dividend = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b_q};
            end
            SQUARE: begin
                red_start    = !issued_q;
                red_dividend = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, b_q};
            end
            default: ;
        endcase
    end

    mod_reduce #(.WIDTH(WIDTH)) u_reduce (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .ready_in      (red_start),
        .dividend_in   (red_dividend),
        .modulus_in    (red_modulus),
        .remainder_out (red_rem),
        .busy_out      (red_busy),
        .valid_out     (red_valid)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            b_q        <= '0;
            m_q        <= '0;
            e_q        <= '0;
            issued_q   <= 1'b0;
            result_out <= '0;
            busy_out   <= 1'b0;
            valid_out  <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    busy_out  <= 1'b1;
                    m_q       <= modulus_in;
                    e_q       <= exponent_in;
                    acc_q     <= WIDTH'(1);
                    issued_q  <= 1'b0;
                    error_out <= (modulus_in == '0);
                    state_q   <= (modulus_in == '0) ? DONE : REDUCE_BASE;
                end
                REDUCE_BASE: if (red_valid) begin
                    b_q <= red_rem;
                    if (e_q[0])             state_q <= MULTIPLY;
                    else if (e_shr != '0)   state_q <= SQUARE;
                    else                    state_q <= DONE;
                end
                MULTIPLY: begin
                    issued_q <= !red_valid && (issued_q || !red_busy);
                    if (red_valid) begin
                        acc_q   <= red_rem;
                        state_q <= (e_shr != '0) ? SQUARE : DONE;
                    end
                end
                SQUARE: begin
                    issued_q <= !red_valid && (issued_q || !red_busy);
                    if (red_valid) begin
                        b_q <= red_rem;
                        e_q <= e_shr;
                        if (e_shr[0])               state_q <= MULTIPLY;
                        else if ((e_shr >> 1) != '0) state_q <= SQUARE;
                        else                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // acc is already reduced except for the untouched initial 1 when m == 1.
                    result_out <= (error_out || m_q == WIDTH'(1)) ? '0 : acc_q;
                    valid_out  <= 1'b1;
                    busy_out   <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at WIDTH=8 and WIDTH=16 with hand-computed results
// and cycle-exact latency checks.
module tb_mod_exp_engine;
    import mod_exp_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;

    logic        ready8 = 1'b0;
    logic [7:0]  base8 = '0, exp8 = '0, mod8 = '0, res8;
    logic        busy8, valid8, err8;

    logic        ready16 = 1'b0;
    logic [15:0] base16 = '0, mod16 = '0, res16;
    logic [7:0]  exp16 = '0;
    logic        busy16, valid16, err16;

    int n_pass = 0;
    int n_total = 0;
    int vcnt8 = 0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (valid8) vcnt8 <= vcnt8 + 1;

    mod_exp_engine #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready8), .base_in(base8),
        .exponent_in(exp8), .modulus_in(mod8), .result_out(res8),
        .busy_out(busy8), .valid_out(valid8), .error_out(err8)
    );

    mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(8)) dut16 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready16), .base_in(base16),
        .exponent_in(exp16), .modulus_in(mod16), .result_out(res16),
        .busy_out(busy16), .valid_out(valid16), .error_out(err16)
    );

    task automatic check(input string tag, input longint observed, input longint expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Repeated multiplication, independent of the square-and-multiply order.
    function automatic longint pow_model(input longint b, input int e, input longint m);
        longint r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * (b % m)) % m;
        return r;
    endfunction

    // Presents one request for a single edge, then scrambles the inputs.
    task automatic start8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
        @(negedge clk_in);
        ready8 = 1'b1; base8 = b; exp8 = e; mod8 = m;
        @(posedge clk_in);
        #1;
        ready8 = 1'b0; base8 = 8'hA5; exp8 = 8'hFF; mod8 = 8'h00;
    endtask

    task automatic start16(input logic [15:0] b, input logic [7:0] e, input logic [15:0] m);
        @(negedge clk_in);
        ready16 = 1'b1; base16 = b; exp16 = e; mod16 = m;
        @(posedge clk_in);
        #1;
        ready16 = 1'b0; base16 = 16'h1234; exp16 = 8'hFF; mod16 = 16'h0000;
    endtask

    // lat counts from the accept edge to the edge at which valid is first sampled high.
    task automatic wait8(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int j = 1; j <= 3000; j++) begin
            @(posedge clk_in);
            #1;
            if (valid8) begin
                lat = j + 1;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
        end
    endtask

    task automatic wait16(output int lat);
        lat = -1;
        for (int j = 1; j <= 3000; j++) begin
            @(posedge clk_in);
            #1;
            if (valid16) begin
                lat = j + 1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        bit bok;
        int vc0;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_result", res8, 0);
        check("rst_busy", busy8, 0);
        check("rst_valid", valid8, 0);
        check("rst_error", err8, 0);
        check("rst_result16", res16, 0);

        // 3^5 mod 7 = 243 mod 7 = 5, N = 5
        start8(8'd3, 8'd5, 8'd7);
        check("b3e5_busy_T1", busy8, 1);
        wait8(lat, bok);
        check("b3e5_latency", lat, 91);
        check("b3e5_busy_held", bok, 1);
        check("b3e5_busy_drop", busy8, 0);
        check("b3e5_result", res8, 5);
        check("b3e5_error", err8, 0);

        // ready held high throughout; back-to-back request picked up after valid
        @(negedge clk_in);
        ready8 = 1'b1; base8 = 8'd200; exp8 = 8'd3; mod8 = 8'd255;
        @(posedge clk_in);
        #1;
        base8 = 8'd7; exp8 = 8'd0; mod8 = 8'd13;
        vc0 = vcnt8;
        check("hold_busy", busy8, 1);
        wait8(lat, bok);
        check("b200e3_latency", lat, 73);
        check("b200e3_result", res8, 140);
        @(posedge clk_in);
        #1;
        ready8 = 1'b0;
        check("b2b_busy", busy8, 1);
        wait8(lat, bok);
        check("b7e0_latency", lat, 19);
        check("b7e0_result", res8, 1);
        repeat (5) @(posedge clk_in);
        #1;
        check("hold_pulses", vcnt8 - vc0, 2);

        // m == 1 must give 0 even with exponent 0
        start8(8'd9, 8'd0, 8'd1);
        wait8(lat, bok);
        check("m1_latency", lat, 19);
        check("m1_result", res8, 0);

        // divide-by-zero flagged two edges after accept
        start8(8'd123, 8'd77, 8'd0);
        wait8(lat, bok);
        check("m0_latency", lat, 2);
        check("m0_error", err8, 1);
        check("m0_result", res8, 0);
        start8(8'd3, 8'd5, 8'd7);
        check("m0_clear_on_accept", err8, 0);
        wait8(lat, bok);
        check("after_m0_result", res8, 5);

        // reset while squaring (exp=2: REDUCE_BASE then SQUARE from edge T+18)
        start8(8'd3, 8'd2, 8'd7);
        repeat (25) @(posedge clk_in);
        vc0 = vcnt8;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_result", res8, 0);
        check("midrst_valid", valid8, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (60) @(posedge clk_in);
        #1;
        check("midrst_no_pulse", vcnt8 - vc0, 0);
        start8(8'd3, 8'd2, 8'd7);
        wait8(lat, bok);
        check("post_rst_latency", lat, 55);
        check("post_rst_result", res8, 2);

        // WIDTH=16: 4^13 mod 497 = 445, N = 1 + 3 + 3 = 7
        start16(16'd4, 8'd13, 16'd497);
        wait16(lat);
        check("w16_b4e13_latency", lat, 239);
        check("w16_b4e13_result", res16, 445);
        start16(16'd65535, 8'd255, 16'd65521);
        wait16(lat);
        check("w16_big_latency", lat, latency_cycles(16, 64'd255));
        check("w16_big_result", res16, pow_model(65535, 255, 65521));
        start16(16'd5, 8'd9, 16'd0);
        wait16(lat);
        check("w16_m0_latency", lat, 2);
        check("w16_m0_error", err16, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
